tone_sequencer: RTL and testbench

//  Plays a short programmed melody through the sine stepper. Holds up to DEPTH

---
 rtl/tone_sequencer_pkg.sv | 15 +
 rtl/tone_sequencer_if.sv | 30 +++
 rtl/tone_sequencer_ms_tick_gen.sv | 35 +++
 rtl/tone_sequencer.sv | 157 +++++++++++++++
 tb/tb_tone_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/tone_sequencer_pkg.sv
// Shared definitions for the tone sequencer: stepper frequency codes and FSM states.
package tone_sequencer_pkg;

  localparam logic [1:0] FREQ_200  = 2'd0;
  localparam logic [1:0] FREQ_400  = 2'd1;
  localparam logic [1:0] FREQ_800  = 2'd2;
  localparam logic [1:0] FREQ_1600 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2
  } state_e;

endpackage

// File: rtl/tone_sequencer_if.sv
// Register-side bundle of the tone sequencer: entry writes, playback control and status.
interface tone_sequencer_if #(
  parameter int DEPTH = 8,
  parameter int DUR_W = 10
) ();
  localparam int IDX_W = $clog2(DEPTH);

  logic             wr_en;
  logic [IDX_W-1:0] wr_addr;
  logic [DUR_W+2:0] wr_data;
  logic [IDX_W:0]   seq_len;
  logic             loop;
  logic             start;
  logic             stop;
  logic [1:0]       frequency;
  logic             tone_en;
  logic             busy;
  logic [IDX_W-1:0] cur_index;
  logic             done;

  modport master (
    output wr_en, wr_addr, wr_data, seq_len, loop, start, stop,
    input  frequency, tone_en, busy, cur_index, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, seq_len, loop, start, stop,
    output frequency, tone_en, busy, cur_index, done
  );
endinterface

// File: rtl/tone_sequencer_ms_tick_gen.sv
// Millisecond tick generator: counts 0..TICK_DIV-1 while enabled, pulses tick_o on the wrap.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == LAST);

endmodule

// File: rtl/tone_sequencer.sv
// Melody player: walks a small note table and drives the sine stepper's
// frequency select and tone enable, with optional looping and abort.
module tone_sequencer
  import tone_sequencer_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int DEPTH    = 8,
  parameter int DUR_W    = 10
) (
  input  logic             clock,
  input  logic             reset,
  tone_sequencer_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LEN_W = IDX_W + 1;
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

  typedef struct packed {
    logic             rest;
    logic [1:0]       freq;
    logic [DUR_W-1:0] dur;
  } entry_t;

  entry_t           mem_q [DEPTH];
  state_e           state_q, state_d;
  logic [IDX_W-1:0] cur_index_q, cur_index_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [1:0]       freq_q, freq_d;
  logic             tone_en_q, tone_en_d;
  logic             done_q, done_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [DUR_W-1:0] ms_q, ms_d;

  entry_t           rd_entry;
  logic             tick;
  logic             advance;
  logic             last_entry;
  logic [LEN_W-1:0] next_pos;

  ms_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .clr_i  (state_q != S_PLAY),
    .en_i   (state_q == S_PLAY),
    .tick_o (tick)
  );

  // Entry memory is not reset; writes are accepted in every state.
  always_ff @(posedge clock) begin
    if (bus.wr_en) begin
      mem_q[bus.wr_addr] <= entry_t'(bus.wr_data);
    end
  end

  assign rd_entry   = mem_q[cur_index_q];
  assign next_pos   = {1'b0, cur_index_q} + LEN_W'(1);
  assign last_entry = (next_pos >= len_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cur_index_q <= '0;
      len_q       <= '0;
      freq_q      <= FREQ_200;
      tone_en_q   <= 1'b0;
      done_q      <= 1'b0;
      ms_q        <= '0;
    end else begin
      state_q     <= state_d;
      cur_index_q <= cur_index_d;
      len_q       <= len_d;
      freq_q      <= freq_d;
      tone_en_q   <= tone_en_d;
      done_q      <= done_d;
      ms_q        <= ms_d;
    end
  end

  always_ff @(posedge clock) begin
    dur_q <= dur_d;
  end

  always_comb begin
    state_d     = state_q;
    cur_index_d = cur_index_q;
    len_d       = len_q;
    freq_d      = freq_q;
    tone_en_d   = tone_en_q;
    done_d      = 1'b0;
    dur_d       = dur_q;
    ms_d        = ms_q;
    advance     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.stop) begin
          len_d       = (bus.seq_len > DEPTH_L) ? DEPTH_L : bus.seq_len;
          cur_index_d = '0;
          if (len_d == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ms_d  = '0;
        dur_d = rd_entry.dur;
        if (rd_entry.dur == '0) begin
          advance = 1'b1;
        end else begin
          freq_d    = rd_entry.freq;
          tone_en_d = ~rd_entry.rest;
          state_d   = S_PLAY;
        end
      end
      S_PLAY: begin
        if (tick) begin
          ms_d = ms_q + DUR_W'(1);
          if (ms_d == dur_q) begin
            advance = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort wins over any end-of-entry move decided above.
    if (bus.stop && (state_q != S_IDLE)) begin
      state_d     = S_IDLE;
      cur_index_d = cur_index_q;
      tone_en_d   = 1'b0;
      done_d      = 1'b1;
    end else if (advance) begin
      if (!last_entry) begin
        cur_index_d = cur_index_q + IDX_W'(1);
        state_d     = S_LOAD;
      end else if (bus.loop) begin
        cur_index_d = '0;
        state_d     = S_LOAD;
      end else begin
        state_d   = S_IDLE;
        tone_en_d = 1'b0;
        done_d    = 1'b1;
      end
    end
  end

  always_comb begin
    bus.frequency = freq_q;
    bus.tone_en   = tone_en_q;
    bus.busy      = (state_q != S_IDLE);
    bus.cur_index = cur_index_q;
    bus.done      = done_q;
  end

endmodule

// File: tb/tb_tone_sequencer.sv
// Scoreboard bench for tone_sequencer: each test queues the output changes it
// expects (cycle + value); a monitor pops one per observed output change.
module tb_tone_sequencer;
  import tone_sequencer_pkg::*;

  localparam int TICK_DIV = 4;
  localparam int DEPTH    = 8;
  localparam int DUR_W    = 10;

  typedef struct {
    int         cyc;
    logic [7:0] v;
    int         tid;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   base = 0;
  int   tid = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  bit   mon_en = 1'b0;
  logic [7:0] prev_v = 8'h00;
  exp_t sb[$];

  tone_sequencer_if #(.DEPTH(DEPTH), .DUR_W(DUR_W)) bus ();

  tone_sequencer #(.TICK_DIV(TICK_DIV), .DEPTH(DEPTH), .DUR_W(DUR_W)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] outs();
    return {bus.frequency, bus.tone_en, bus.busy, bus.cur_index, bus.done};
  endfunction

  // Monitor: every change of the output tuple must match the next queued expectation.
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t e;
    if (mon_en) begin
      cur = outs();
      if (cur !== prev_v) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=none", cyc, cur);
        end else begin
          e = sb.pop_front();
          if (e.cyc != cyc || e.v !== cur) begin
            n_fail++;
            $display("FAIL test%0d_event got cyc=%0d val=%h required cyc=%0d val=%h",
                     e.tid, cyc, cur, e.cyc, e.v);
          end
        end
        prev_v = cur;
      end
    end
  end

  task automatic ex(input int off, input int f, input int t, input int b, input int i, input int d);
    exp_t e;
    e.cyc = base + off;
    e.v   = {2'(f), 1'(t), 1'(b), 3'(i), 1'(d)};
    e.tid = tid;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int t);
    while (cyc < t) step();
  endtask

  task automatic wr(input int a, input int rest, input int f, input int dur);
    bus.wr_en   = 1'b1;
    bus.wr_addr = 3'(a);
    bus.wr_data = {1'(rest), 2'(f), 10'(dur)};
    step();
    bus.wr_en   = 1'b0;
  endtask

  task automatic go(input int len, input bit lp);
    bus.seq_len = 4'(len);
    bus.loop    = lp;
    base        = cyc;
    bus.start   = 1'b1;
    step();
    bus.start   = 1'b0;
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
    bus.seq_len = '0; bus.loop = 1'b0; bus.start = 1'b0; bus.stop = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (outs() !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_state got=%h required=00", outs());
    end
    prev_v = 8'h00;
    mon_en = 1'b1;

    // 1: single entry, freq 2, 3 ms
    tid = 1;
    wr(0, 0, 2, 3);
    go(1, 0);
    ex(1, 0,0,1,0,0); ex(2, 2,1,1,0,0); ex(14, 2,0,0,0,1); ex(15, 2,0,0,0,0);
    wait_cyc(base + 18);

    // 2: three entries with one LOAD cycle holding the previous tone
    tid = 2;
    wr(0, 0, 0, 1); wr(1, 0, 1, 2); wr(2, 0, 3, 1);
    go(3, 0);
    ex(1, 2,0,1,0,0); ex(2, 0,1,1,0,0); ex(6, 0,1,1,1,0); ex(7, 1,1,1,1,0);
    ex(15, 1,1,1,2,0); ex(16, 3,1,1,2,0); ex(20, 3,0,0,2,1); ex(21, 3,0,0,2,0);
    wait_cyc(base + 24);

    // 3: rest entry then a zero-duration skip
    tid = 3;
    wr(0, 0, 1, 1); wr(1, 1, 2, 1); wr(2, 0, 3, 0); wr(3, 0, 2, 1);
    go(4, 0);
    ex(1, 3,0,1,0,0); ex(2, 1,1,1,0,0); ex(6, 1,1,1,1,0); ex(7, 2,0,1,1,0);
    ex(11, 2,0,1,2,0); ex(12, 2,0,1,3,0); ex(13, 2,1,1,3,0);
    ex(17, 2,0,0,3,1); ex(18, 2,0,0,3,0);
    wait_cyc(base + 21);

    // 4: loop over two entries, loop dropped during second pass of entry 1
    tid = 4;
    wr(0, 0, 1, 1); wr(1, 0, 2, 1);
    go(2, 1);
    ex(1, 2,0,1,0,0); ex(2, 1,1,1,0,0); ex(6, 1,1,1,1,0); ex(7, 2,1,1,1,0);
    ex(11, 2,1,1,0,0); ex(12, 1,1,1,0,0); ex(16, 1,1,1,1,0); ex(17, 2,1,1,1,0);
    ex(21, 2,0,0,1,1); ex(22, 2,0,0,1,0);
    wait_cyc(base + 18);
    bus.loop = 1'b0;
    wait_cyc(base + 25);

    // 5: stop with start mid-PLAY, restart, then reset mid-PLAY
    tid = 5;
    go(2, 0);
    ex(1, 2,0,1,0,0); ex(2, 1,1,1,0,0); ex(4, 1,0,0,0,1); ex(5, 1,0,0,0,0);
    wait_cyc(base + 3);
    bus.stop = 1'b1; bus.start = 1'b1;
    step();
    bus.stop = 1'b0; bus.start = 1'b0;
    wait_cyc(base + 8);
    go(2, 0);
    ex(1, 1,0,1,0,0); ex(2, 1,1,1,0,0); ex(5, 0,0,0,0,0);
    wait_cyc(base + 4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    wait_cyc(base + 8);

    // 6: zero length gives done only; stop in IDLE does nothing
    tid = 6;
    go(0, 0);
    ex(1, 0,0,0,0,1); ex(2, 0,0,0,0,0);
    wait_cyc(base + 4);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    wait_cyc(base + 8);

    // 7: start while busy is ignored
    tid = 7;
    wr(0, 0, 1, 2);
    go(1, 0);
    ex(1, 0,0,1,0,0); ex(2, 1,1,1,0,0); ex(10, 1,0,0,0,1); ex(11, 1,0,0,0,0);
    wait_cyc(base + 4);
    bus.seq_len = 4'd3; bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_cyc(base + 14);

    // 8: rewrite entry 2 while entry 1 plays
    tid = 8;
    wr(0, 0, 1, 1); wr(1, 0, 2, 2); wr(2, 0, 0, 1);
    go(3, 0);
    ex(1, 1,0,1,0,0); ex(2, 1,1,1,0,0); ex(6, 1,1,1,1,0); ex(7, 2,1,1,1,0);
    ex(15, 2,1,1,2,0); ex(16, 3,1,1,2,0); ex(20, 3,0,0,2,1); ex(21, 3,0,0,2,0);
    wait_cyc(base + 9);
    wr(2, 0, 3, 1);
    wait_cyc(base + 24);

    // 9: seq_len above DEPTH plays all DEPTH entries
    tid = 9;
    for (int k = 0; k < DEPTH; k++) wr(k, 0, k % 4, 1);
    go(12, 0);
    ex(1, 3,0,1,0,0); ex(2, 0,1,1,0,0);
    for (int k = 1; k < DEPTH; k++) begin
      ex(1 + 5*k, (k-1) % 4, 1, 1, k, 0);
      ex(2 + 5*k, k % 4, 1, 1, k, 0);
    end
    ex(41, 3,0,0,7,1); ex(42, 3,0,0,7,0);
    wait_cyc(base + 46);

    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      n_fail++;
      $display("FAIL test%0d_missing got=none required cyc=%0d val=%h", e.tid, e.cyc, e.v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
